// File: rtl/mux4_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 lane multiplexer.
// Grants one lane at a time for a burst of up to MAX_BURST transfers on a valid/ready port.
module mux4_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] in_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      sel,
    output logic [3:0]      grant,
    output logic            busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic [0:0] state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] cnt_inc_s;
    logic       xfer_s;

    // First requesting lane searching upward from last+1; k=4 wraps back to last itself.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Output valid and transfer strobe come straight from the registered select.
    always_comb begin
        out_valid = (state_q == GRANT) && req[sel_q];
        xfer_s    = out_valid && out_ready;
        cnt_inc_s = cnt_q + 4'd1;
    end

    // Shared 4:1 data mux, live in every state.
    always_comb begin
        out_data = in_data[DW-1:0];
        case (sel_q)
            2'd0:    out_data = in_data[0*DW +: DW];
            2'd1:    out_data = in_data[1*DW +: DW];
            2'd2:    out_data = in_data[2*DW +: DW];
            2'd3:    out_data = in_data[3*DW +: DW];
            default: out_data = in_data[0*DW +: DW];
        endcase
    end

    // Next-state logic: arbitration in IDLE, burst accounting and release in GRANT.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_d   = rr_pick(req, last_q);
                    grant_d = 4'b0001 << sel_d;
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end else begin
                    grant_d = 4'b0000;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    last_d  = sel_q;
                    cnt_d   = 4'd0;
                end else if (xfer_s) begin
                    if (cnt_inc_s == BURST_LIM) begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        last_d  = sel_q;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers; last resets to lane 3 so lane 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            cnt_q   <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a lane/beat-count reference model.
module tb_mux4_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [4*DW-1:0] in_data;
    logic            out_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      sel;
    logic [3:0]      grant;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: granted lane (-1 = idle), select, last granted lane, beats so far.
    int m_lane, m_sel, m_last, m_beats;

    mux4_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .sel(sel), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lane = -1; m_sel = 0; m_last = 3; m_beats = 0;
    endtask

    task automatic model_update();
        bit found;
        int c;
        found = 1'b0;
        if (m_lane < 0) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (!found && req[c]) begin
                    found = 1'b1; m_lane = c; m_sel = c; m_beats = 0;
                end
            end
        end else if (!req[m_lane]) begin
            m_last = m_lane; m_lane = -1;
        end else if (out_ready) begin
            m_beats++;
            if (m_beats == MB) begin
                m_last = m_lane; m_lane = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0]    e_grant;
        logic          e_valid;
        logic [DW-1:0] e_data;
        e_grant = (m_lane >= 0) ? 4'(1 << m_lane) : 4'b0000;
        e_valid = (m_lane >= 0) && req[m_lane];
        e_data  = DW'(in_data >> (m_sel * DW));
        chk("grant",     32'(grant),     32'(e_grant));
        chk("sel",       32'(sel),       32'(m_sel));
        chk("busy",      32'(busy),      32'(m_lane >= 0));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_data",  32'(out_data),  32'(e_data));
    endtask

    // One cycle: drive at negedge (reset acts immediately), check, then advance model at posedge.
    task automatic step(input logic rn, input logic [3:0] r, input logic rdy, input logic [31:0] d);
        @(negedge clk);
        rst_n = rn; req = r; out_ready = rdy; in_data = d;
        if (!rn) model_reset();
        #1;
        compare_all();
        @(posedge clk);
        if (rst_n) model_update();
    endtask

    task automatic do_reset();
        step(1'b0, 4'b1111, 1'b1, 32'h4433_2211);
        step(1'b0, 4'b1111, 1'b1, 32'h4433_2211);
    endtask

    initial begin
        logic [3:0]  r;
        logic [31:0] d;
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1; in_data = 32'h4433_2211;
        model_reset();
        #2;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);

        // Fairness: all lanes requesting, lanes rotate 0,1,2,3,0 with 4-beat bursts.
        do_reset();
        for (int i = 0; i < 27; i++) step(1'b1, 4'b1111, 1'b1, 32'hDDCC_BBAA);

        // Early withdraw: lane 2 drops after 2 beats, lane 3 gets the next grant.
        do_reset();
        step(1'b1, 4'b0100, 1'b1, 32'h0011_2233);
        step(1'b1, 4'b0100, 1'b1, 32'h0011_2233);
        step(1'b1, 4'b0100, 1'b1, 32'h0011_2233);
        step(1'b1, 4'b1000, 1'b1, 32'h0011_2233);
        step(1'b1, 4'b1000, 1'b1, 32'h0011_2233);
        #1;
        chk("withdraw_next", 32'(grant), 32'h8);

        // Backpressure: lane 1 held with out_ready low, then drained.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0010, 1'b0, 32'h0000_A500);
        for (int i = 0; i < 6; i++)  step(1'b1, 4'b0010, 1'b1, 32'h0000_A500);

        // Single requester on lane 2.
        for (int i = 0; i < 15; i++) step(1'b1, 4'b0100, 1'b1, 32'h0077_0000);

        // Mid-burst reset on lane 3 after two beats, then lane 3 again.
        do_reset();
        step(1'b1, 4'b1000, 1'b1, 32'h5A00_0000);
        step(1'b1, 4'b1000, 1'b1, 32'h5A00_0000);
        step(1'b1, 4'b1000, 1'b1, 32'h5A00_0000);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_grant", 32'(grant), 32'h0);
        chk("midreset_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        for (int i = 0; i < 7; i++) step(1'b1, 4'b1000, 1'b1, 32'h5A00_0000);

        // Randomized traffic with occasional backpressure, withdrawal and reset.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = $urandom;
            step(($urandom_range(0, 199) != 0), r, ($urandom_range(0, 3) != 0), d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin scheduler that shares a single 4:1 data multiplexer between four requesters. It owns the mux select, grants one requester at a time for a bounded burst, and presents the selected lane on a valid/ready output port. It sits directly in front of the 4:1 mux datapath and is the only block allowed to drive its select lines.

## Interface
- DW, 8, data width of each input lane and of the output.
- MAX_BURST, 4, maximum transfers per grant (1..15).
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- req  input  4  request per lane; bit i high means lane i has a beat on in_data[i*DW +: DW].
- in_data  input  4*DW  packed lane data, lane 0 in the LSBs.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_valid  output  1  out_data holds a beat from the granted lane.
- out_data  output  DW  selected lane data.
- sel  output  2  registered mux select (encoded granted lane).
- grant  output  4  registered one-hot grant; all-zero when idle.
- busy  output  1  high while in GRANT state.

## Operation
- Two-state FSM: IDLE, GRANT.
- IDLE: grant = 0, out_valid = 0. If req != 0, pick the first requesting lane searching upward (mod 4) from last+1, where last is the most recently granted lane. Load sel, grant, and clear beat counter; move to GRANT on the next edge. If req == 0, stay in IDLE.
- GRANT: out_valid = req[sel] (combinational). out_data = in_data[sel*DW +: DW] (combinational through the mux, in every state).
- Transfer occurs when out_valid && out_ready; beat counter (4 bits) increments on each transfer.
- Release to IDLE on the edge after either: req[sel] low (requester withdrew, no transfer that cycle), or a transfer that makes the counter equal MAX_BURST. On release, last <= sel, grant <= 0. sel holds its value while IDLE.
- Requests from non-granted lanes never pre-empt an active grant.
- Requesters must hold data stable while req is high and not accepted; the arbiter does not buffer data.
- Reset values: state IDLE, sel = 2'b00, grant = 4'b0000, busy = 0, out_valid = 0, counter = 0, last = 2'd3 (lane 0 has first priority).

## Timing
- Arbitration latency: req rising in cycle N (in IDLE) gives grant/sel valid in cycle N+1; first transfer possible in N+1.
- One mandatory IDLE bubble cycle between consecutive grants; peak throughput MAX_BURST/(MAX_BURST+1).
- out_valid, out_data are combinational from registered sel plus req/in_data; no added latency.
- Counter reaching MAX_BURST and req[sel] falling in the same cycle: single release, last <= sel.
- out_ready low holds the grant indefinitely (counter frozen); no timeout.
- rst_n asserted mid-burst: all outputs go to reset values immediately (asynchronous), in-flight beat is dropped; after release lane 0 has priority.
- Priority pointer wraps 3 -> 0.

## Test plan
- Reset: rst_n low with req = 4'b1111 -> grant = 0, sel = 0, out_valid = 0; release -> next cycle grant = 4'b0001, sel = 0.
- Fairness: req = 4'b1111 held, out_ready = 1, MAX_BURST = 4 -> grants cycle lanes 0,1,2,3,0, each exactly 4 transfers, one idle cycle between.
- Early withdraw: grant lane 2, lane 2 drops req after 2 transfers -> release, next grant goes to lane 3 if requesting, else wraps to 0.
- Backpressure: lane 1 granted, out_ready = 0 for 10 cycles -> out_valid stays 1, out_data = lane 1 data (e.g. 8'hA5), counter stays 0, grant unchanged.
- Single requester: only req[2] high -> repeated 4-beat grants to lane 2 separated by one idle cycle; out_data equals in_data[23:16].
- Mid-burst reset: assert rst_n low after 2 beats on lane 3 -> out_valid and grant drop in the same cycle; after release with req = 4'b1000, lane 3 granted and counter starts at 0.
